// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS main control FSM. The
// ALU control unit and the testbench import it as well.
//   - opcode constants (IR[31:26])
//   - state encodings (state_t)
//   - ALUop, ALUSrcB and PCSource code constants
//   - ctrl_t, the packed control word produced by mc_ctrl_decode
// Optional feature macro: MC_JUMP_EN (adds the JUMP state for opcode j).
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Opcodes recognised by the main control
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUop codes sent to the ALU control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // ALUSrcB mux selects
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PCSource mux selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM state encodings; 12-14 are unused and recover into TRAP
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
`ifdef MC_JUMP_EN
    ST_JUMP   = 4'd11,
`endif
    ST_TRAP   = 4'd15
  } state_t;

  // Full datapath control word for one cycle
  typedef struct packed {
    logic       pcWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] pcSource;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       addi;
    logic       instrDone;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
// Purely combinational decode of the current FSM state into the datapath
// control word. Moore in the state, with two Mealy terms: mem_ready in
// FETCH/MEMWR and the ALU zero flag in BRANCH.
// Ports:
//   i_state     current state encoding
//   i_zero      ALU zero flag
//   i_memReady  memory completes the access this cycle
//   o_ctrlWord  packed ctrl_t control word
// Optional feature macro: MC_JUMP_EN (decodes the JUMP state).
// ---------------------------------------------------------------------------
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0]        i_state,
  input  logic              i_zero,
  input  logic              i_memReady,
  output logic [CTRL_W-1:0] o_ctrlWord
);

  ctrl_t w_ctrl;

  // Every control defaults to 0 so each state lists only what it asserts.
  // TRAP and the unused encodings fall through to the all-zero word.
  always_comb begin
    w_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        // IR and PC only update on the cycle the fetch actually completes
        w_ctrl.memRead  = 1'b1;
        w_ctrl.aluSrcB  = SRCB_FOUR;
        w_ctrl.aluOp    = ALUOP_ADD;
        w_ctrl.pcSource = PCSRC_ALU;
        w_ctrl.irWrite  = i_memReady;
        w_ctrl.pcWrite  = i_memReady;
      end
      ST_DECODE: begin
        // Branch target computed speculatively into ALUOut
        w_ctrl.aluSrcB = SRCB_IMMSH;
        w_ctrl.aluOp   = ALUOP_ADD;
      end
      ST_MEMADR: begin
        w_ctrl.aluSrcA = 1'b1;
        w_ctrl.aluSrcB = SRCB_IMM;
        w_ctrl.aluOp   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        w_ctrl.memRead = 1'b1;
        w_ctrl.iorD    = 1'b1;
      end
      ST_MEMWB: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.memtoReg  = 1'b1;
        w_ctrl.instrDone = 1'b1;
      end
      ST_MEMWR: begin
        // The store only finishes once memory accepts it
        w_ctrl.memWrite  = 1'b1;
        w_ctrl.iorD      = 1'b1;
        w_ctrl.instrDone = i_memReady;
      end
      ST_EXEC: begin
        w_ctrl.aluSrcA = 1'b1;
        w_ctrl.aluSrcB = SRCB_REGB;
        w_ctrl.aluOp   = ALUOP_RTYPE;
      end
      ST_ALUWB: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.regDst    = 1'b1;
        w_ctrl.instrDone = 1'b1;
      end
      ST_BRANCH: begin
        // Conditional PC write folded in here rather than a separate PCWriteCond
        w_ctrl.aluSrcA   = 1'b1;
        w_ctrl.aluSrcB   = SRCB_REGB;
        w_ctrl.aluOp     = ALUOP_SUB;
        w_ctrl.pcSource  = PCSRC_ALUOUT;
        w_ctrl.pcWrite   = i_zero;
        w_ctrl.instrDone = 1'b1;
      end
      ST_ADDIEX: begin
        w_ctrl.aluSrcA = 1'b1;
        w_ctrl.aluSrcB = SRCB_IMM;
        w_ctrl.aluOp   = ALUOP_ADD;
        w_ctrl.addi    = 1'b1;
      end
      ST_ADDIWB: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.instrDone = 1'b1;
      end
`ifdef MC_JUMP_EN
      ST_JUMP: begin
        w_ctrl.pcWrite   = 1'b1;
        w_ctrl.pcSource  = PCSRC_JUMP;
        w_ctrl.instrDone = 1'b1;
      end
`endif
      default: w_ctrl = '0;
    endcase
  end

  assign o_ctrlWord = w_ctrl;

endmodule

// File: rtl/mc_main_control.sv
// ---------------------------------------------------------------------------
// mc_main_control
// Multi-cycle MIPS main control FSM: fetch, decode, execute, memory and
// write-back one state per clock, stalling in memory states until
// mem_ready. Holds the state register, next-state logic, the sticky
// illegal_op flag and the reset gating of all outputs; the control word
// itself comes from mc_ctrl_decode.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode              IR[31:26]
//   zero                ALU zero flag (BRANCH)
//   mem_ready           memory handshake
//   PCWrite..ALUSrcA    1-bit datapath controls
//   PCSource, ALUSrcB   2-bit mux selects
//   ALUop, addi         to the ALU control unit
//   instr_done          one-cycle pulse at the end of each instruction
//   illegal_op          sticky illegal-opcode flag
//   state               current state, for debug
// Optional feature macro: MC_JUMP_EN (decode j into the JUMP state;
// otherwise j traps like any other unknown opcode).
// ---------------------------------------------------------------------------
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           MemtoReg,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic           RegDst,
  output logic           ALUSrcA,
  output logic [1:0]     PCSource,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUop,
  output logic           addi,
  output logic           instr_done,
  output logic           illegal_op,
  output logic [3:0]     state
);

  state_t            r_state;
  state_t            w_nextState;
  logic              r_illegal;
  logic [CTRL_W-1:0] w_ctrlWord;
  ctrl_t             w_ctrl;

  // Next-state logic. Stalling states hold until mem_ready; anything that
  // is not a known state (12-14) lands in TRAP.
  always_comb begin
    w_nextState = ST_TRAP;
    case (r_state)
      ST_FETCH:  w_nextState = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_nextState = ST_MEMADR;
          OP_RTYPE:     w_nextState = ST_EXEC;
          OP_BEQ:       w_nextState = ST_BRANCH;
          OP_ADDI:      w_nextState = ST_ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         w_nextState = ST_JUMP;
`endif
          default:      w_nextState = ST_TRAP;
        endcase
      end
      ST_MEMADR: w_nextState = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  w_nextState = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  w_nextState = ST_FETCH;
      ST_MEMWR:  w_nextState = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   w_nextState = ST_ALUWB;
      ST_ALUWB:  w_nextState = ST_FETCH;
      ST_BRANCH: w_nextState = ST_FETCH;
      ST_ADDIEX: w_nextState = ST_ADDIWB;
      ST_ADDIWB: w_nextState = ST_FETCH;
`ifdef MC_JUMP_EN
      ST_JUMP:   w_nextState = ST_FETCH;
`endif
      ST_TRAP:   w_nextState = ST_TRAP;
      default:   w_nextState = ST_TRAP;
    endcase
  end

  // State register and sticky illegal flag. The flag is set on the edge
  // that enters TRAP so it is already high in the first TRAP cycle, and
  // only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState == ST_TRAP) begin
        r_illegal <= 1'b1;
      end
    end
  end

  mc_ctrl_decode u_decode (
    .i_state    (r_state),
    .i_zero     (zero),
    .i_memReady (mem_ready),
    .o_ctrlWord (w_ctrlWord)
  );

  assign w_ctrl = ctrl_t'(w_ctrlWord);

  // Reset forces every output low in the same cycle, so an instruction
  // interrupted by reset can never issue a write on its way out.
  assign PCWrite    = rst ? 1'b0 : w_ctrl.pcWrite;
  assign IorD       = rst ? 1'b0 : w_ctrl.iorD;
  assign MemRead    = rst ? 1'b0 : w_ctrl.memRead;
  assign MemWrite   = rst ? 1'b0 : w_ctrl.memWrite;
  assign MemtoReg   = rst ? 1'b0 : w_ctrl.memtoReg;
  assign IRWrite    = rst ? 1'b0 : w_ctrl.irWrite;
  assign RegWrite   = rst ? 1'b0 : w_ctrl.regWrite;
  assign RegDst     = rst ? 1'b0 : w_ctrl.regDst;
  assign ALUSrcA    = rst ? 1'b0 : w_ctrl.aluSrcA;
  assign PCSource   = rst ? 2'b00 : w_ctrl.pcSource;
  assign ALUSrcB    = rst ? 2'b00 : w_ctrl.aluSrcB;
  assign ALUop      = rst ? 2'b00 : w_ctrl.aluOp;
  assign addi       = rst ? 1'b0 : w_ctrl.addi;
  assign instr_done = rst ? 1'b0 : w_ctrl.instrDone;
  assign illegal_op = rst ? 1'b0 : r_illegal;
  assign state      = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_mc_main_control.sv
// ---------------------------------------------------------------------------
// tb_mc_main_control
// Self-checking bench for mc_main_control. A table of per-cycle vectors
// (inputs plus hand-computed state, control word and illegal_op) walks
// through lw, sw with stalls, beq taken/not taken, R-type, addi, reset
// mid-instruction, j and an illegal opcode; a hand-written sequence then
// checks a lw stalled in MEMRD produces a single instr_done pulse.
// Build with +define+MC_JUMP_EN to exercise the JUMP state.
// ---------------------------------------------------------------------------
module tb_mc_main_control;
  import mc_ctrl_pkg::*;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [5:0] opcode    = OP_RTYPE;
  logic       zero      = 1'b0;
  logic       mem_ready = 1'b1;

  logic       PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       RegWrite, RegDst, ALUSrcA, addi, instr_done, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUop;
  logic [3:0] state;

  int checkCount = 0;
  int errorCount = 0;

  mc_main_control #(.OPW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .ALUSrcA    (ALUSrcA),
    .PCSource   (PCSource),
    .ALUSrcB    (ALUSrcB),
    .ALUop      (ALUop),
    .addi       (addi),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Observed control word, field order:
  // PCWrite IorD MemRead MemWrite MemtoReg IRWrite RegWrite RegDst ALUSrcA
  // PCSource[1:0] ALUSrcB[1:0] ALUop[1:0] addi instr_done
  logic [16:0] actCtrl;
  assign actCtrl = {PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                    RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUop,
                    addi, instr_done};

  // Hand-computed expected control words, same field order as actCtrl
  localparam logic [16:0] C_ZERO      = 17'b0;
  localparam logic [16:0] C_FETCH_RDY = {9'b1_0_1_0_0_1_0_0_0, 2'b00, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] C_FETCH_WT  = {9'b0_0_1_0_0_0_0_0_0, 2'b00, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] C_DECODE    = {9'b0_0_0_0_0_0_0_0_0, 2'b00, 2'b11, 2'b00, 2'b00};
  localparam logic [16:0] C_MEMADR    = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] C_MEMRD     = {9'b0_1_1_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] C_MEMWB     = {9'b0_0_0_0_1_0_1_0_0, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [16:0] C_MEMWR_WT  = {9'b0_1_0_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] C_MEMWR_RDY = {9'b0_1_0_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [16:0] C_EXEC      = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 2'b10, 2'b00};
  localparam logic [16:0] C_ALUWB     = {9'b0_0_0_0_0_0_1_1_0, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [16:0] C_BR_Z1     = {9'b1_0_0_0_0_0_0_0_1, 2'b01, 2'b00, 2'b01, 2'b01};
  localparam logic [16:0] C_BR_Z0     = {9'b0_0_0_0_0_0_0_0_1, 2'b01, 2'b00, 2'b01, 2'b01};
  localparam logic [16:0] C_ADDIEX    = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b10, 2'b00, 2'b10};
  localparam logic [16:0] C_ADDIWB    = {9'b0_0_0_0_0_0_1_0_0, 2'b00, 2'b00, 2'b00, 2'b01};
`ifdef MC_JUMP_EN
  localparam logic [16:0] C_JUMP      = {9'b1_0_0_0_0_0_0_0_0, 2'b10, 2'b00, 2'b00, 2'b01};
`endif

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  expState;
    logic [16:0] expCtrl;
    logic        expIll;
  } vec_t;

  vec_t vecs[$];

  // Append one cycle to the vector table
  task automatic addVec(input logic r, input logic [5:0] op, input logic z,
                        input logic rdy, input logic [3:0] st,
                        input logic [16:0] c, input logic ill);
    vec_t v;
    v.rst = r; v.op = op; v.zero = z; v.rdy = rdy;
    v.expState = st; v.expCtrl = c; v.expIll = ill;
    vecs.push_back(v);
  endtask

  // One comparison: counts it and reports a FAIL line on mismatch
  task automatic checkValue(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Drive a vector's inputs away from the rising edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    opcode    = v.op;
    zero      = v.zero;
    mem_ready = v.rdy;
  endtask

  // Compare after the combinational outputs have settled
  task automatic checkOutput(input vec_t v, input int idx);
    #1;
    checkValue("state", idx, {28'd0, state}, {28'd0, v.expState});
    checkValue("ctrl", idx, {15'd0, actCtrl}, {15'd0, v.expCtrl});
    checkValue("illegal_op", idx, {31'd0, illegal_op}, {31'd0, v.expIll});
  endtask

  // Global watchdog so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int doneCount;
    int doneCycle;
    logic r0;
    r0 = 1'b0;

    // ---------------- vector table ----------------
    addVec(1, OP_LW, 0, 1, 4'd0, C_ZERO, 0);          // reset
    // lw, no stalls: 0,1,2,3,4
    addVec(r0, OP_LW, 0, 1, 4'd0, C_FETCH_RDY, 0);
    addVec(r0, OP_LW, 0, 1, 4'd1, C_DECODE, 0);
    addVec(r0, OP_LW, 0, 1, 4'd2, C_MEMADR, 0);
    addVec(r0, OP_LW, 0, 1, 4'd3, C_MEMRD, 0);
    addVec(r0, OP_LW, 0, 1, 4'd4, C_MEMWB, 0);
    // sw with two wait cycles in MEMWR
    addVec(r0, OP_SW, 0, 1, 4'd0, C_FETCH_RDY, 0);
    addVec(r0, OP_SW, 0, 1, 4'd1, C_DECODE, 0);
    addVec(r0, OP_SW, 0, 1, 4'd2, C_MEMADR, 0);
    addVec(r0, OP_SW, 0, 0, 4'd5, C_MEMWR_WT, 0);
    addVec(r0, OP_SW, 0, 0, 4'd5, C_MEMWR_WT, 0);
    addVec(r0, OP_SW, 0, 1, 4'd5, C_MEMWR_RDY, 0);
    // beq taken, with one fetch stall first
    addVec(r0, OP_BEQ, 1, 0, 4'd0, C_FETCH_WT, 0);
    addVec(r0, OP_BEQ, 1, 1, 4'd0, C_FETCH_RDY, 0);
    addVec(r0, OP_BEQ, 1, 0, 4'd1, C_DECODE, 0);    // mem_ready ignored
    addVec(r0, OP_BEQ, 1, 1, 4'd8, C_BR_Z1, 0);
    // beq not taken
    addVec(r0, OP_BEQ, 0, 1, 4'd0, C_FETCH_RDY, 0);
    addVec(r0, OP_BEQ, 0, 1, 4'd1, C_DECODE, 0);
    addVec(r0, OP_BEQ, 0, 1, 4'd8, C_BR_Z0, 0);
    // R-type
    addVec(r0, OP_RTYPE, 0, 1, 4'd0, C_FETCH_RDY, 0);
    addVec(r0, OP_RTYPE, 0, 1, 4'd1, C_DECODE, 0);
    addVec(r0, OP_RTYPE, 0, 0, 4'd6, C_EXEC, 0);    // mem_ready ignored
    addVec(r0, OP_RTYPE, 0, 1, 4'd7, C_ALUWB, 0);
    // addi
    addVec(r0, OP_ADDI, 0, 1, 4'd0, C_FETCH_RDY, 0);
    addVec(r0, OP_ADDI, 0, 1, 4'd1, C_DECODE, 0);
    addVec(r0, OP_ADDI, 0, 1, 4'd9, C_ADDIEX, 0);
    addVec(r0, OP_ADDI, 0, 1, 4'd10, C_ADDIWB, 0);
    // lw abandoned by reset in MEMRD
    addVec(r0, OP_LW, 0, 1, 4'd0, C_FETCH_RDY, 0);
    addVec(r0, OP_LW, 0, 1, 4'd1, C_DECODE, 0);
    addVec(r0, OP_LW, 0, 1, 4'd2, C_MEMADR, 0);
    addVec(1, OP_LW, 0, 1, 4'd0, C_ZERO, 0);
    // j: JUMP when enabled, TRAP otherwise
    addVec(r0, OP_J, 0, 1, 4'd0, C_FETCH_RDY, 0);
    addVec(r0, OP_J, 0, 1, 4'd1, C_DECODE, 0);
`ifdef MC_JUMP_EN
    addVec(r0, OP_J, 0, 1, 4'd11, C_JUMP, 0);
`else
    addVec(r0, OP_J, 0, 1, 4'd15, C_ZERO, 1);
`endif
    addVec(1, OP_J, 0, 1, 4'd0, C_ZERO, 0);
    // illegal opcode: TRAP sticks for 10 cycles, then reset clears it
    addVec(r0, 6'b111111, 0, 1, 4'd0, C_FETCH_RDY, 0);
    addVec(r0, 6'b111111, 0, 1, 4'd1, C_DECODE, 0);
    for (int i = 0; i < 10; i++) begin
      addVec(r0, 6'b111111, i[0], i[1], 4'd15, C_ZERO, 1);
    end
    addVec(1, 6'b111111, 0, 1, 4'd0, C_ZERO, 0);
    addVec(r0, OP_LW, 0, 0, 4'd0, C_FETCH_WT, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // ---------------- lw stalled three cycles in MEMRD ----------------
    // Cycle plan: reset, FETCH, DECODE, MEMADR, MEMRD x4 (3 waits), MEMWB.
    @(negedge clk); rst = 1'b1; opcode = OP_LW; mem_ready = 1'b1;
    doneCount = 0;
    doneCycle = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 6) begin
        checkValue("memrd_hold_state", c, {28'd0, state}, 32'd3);
        checkValue("memrd_hold_ctrl", c, {15'd0, actCtrl}, {15'd0, C_MEMRD});
      end
      if (instr_done) begin
        doneCount++;
        doneCycle = c;
      end
    end
    checkValue("lw_stall_done_count", 0, doneCount, 32'd1);
    checkValue("lw_stall_done_cycle", 0, doneCycle, 32'd7);
    @(negedge clk);
    #1;
    checkValue("lw_stall_back_to_fetch", 0, {28'd0, state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
